// File: rtl/baud_gen_frac_pkg.sv
// Shared constants and helpers for the fractional UART baud tick generator.
package baud_gen_frac_pkg;

  // Default rx oversample ratio and the matching phase-index width.
  localparam int OSR_DEFAULT = 16;
  localparam int OSR_LOG2    = $clog2(OSR_DEFAULT);

  // Divisor after reset: 50 MHz / (115200 * 16) = 27.127 -> 27 + 2/16.
  localparam int RESET_DIV_INT_DEFAULT  = 27;
  localparam int RESET_DIV_FRAC_DEFAULT = 2;

  // A zero integer divisor is treated as 1 so the divider never stalls.
  function automatic logic [31:0] eff_int(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // Integer part of the tx period: eff_int*OSR plus the whole clocks that
  // the scaled fraction contributes. Shifts only, since OSR is a power of two.
  function automatic logic [63:0] tx_scale_int(input logic [31:0] eff,
                                               input logic [31:0] frac,
                                               input int          osr_log2,
                                               input int          frac_w);
    logic [63:0] whole;
    logic [63:0] spill;
    whole = 64'(eff) << osr_log2;
    spill = (64'(frac) << osr_log2) >> frac_w;
    return whole + spill;
  endfunction

  // Fraction left over after scaling div_frac by OSR.
  function automatic logic [31:0] tx_scale_frac(input logic [31:0] frac,
                                                input int          osr_log2,
                                                input int          frac_w);
    logic [63:0] scaled;
    logic [63:0] mask;
    scaled = 64'(frac) << osr_log2;
    mask   = (64'd1 << frac_w) - 64'd1;
    scaled = scaled & mask;
    return scaled[31:0];
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// One fractional divider channel: a down-counter whose reload alternates
// between int and int+1 so the average period is int + frac/2^FRAC_W.
module baud_frac_div #(
  parameter int                INT_W    = 16,
  parameter int                FRAC_W   = 4,
  parameter logic [INT_W-1:0]  RST_INT  = INT_W'(1),
  parameter logic [FRAC_W-1:0] RST_FRAC = '0,
  parameter logic [INT_W-1:0]  RST_CNT  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [INT_W-1:0]  int_i,      // already clamped to >= 1
  input  logic [FRAC_W-1:0] frac_i,
  input  logic              load_ok_i,  // adopt int_i/frac_i at the next tick
  input  logic              restart_i,  // restart the period from int_i/frac_i
  output logic              tick_o
);

  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [INT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [INT_W-1:0]  use_int;
  logic [FRAC_W-1:0] use_frac;
  logic [FRAC_W:0]   sum;

  // A restart always wins over a due tick so the caller sees no pulse.
  assign tick_o = en_i && !restart_i && (cnt_q == '0);

  // Next-state: restart, reload at the period boundary, or count down.
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    use_int    = load_ok_i ? int_i  : act_int_q;
    use_frac   = load_ok_i ? frac_i : act_frac_q;
    sum        = {1'b0, acc_q} + {1'b0, use_frac};
    if (restart_i) begin
      cnt_d      = int_i - INT_W'(1);
      acc_d      = '0;
      act_int_d  = int_i;
      act_frac_d = frac_i;
    end else if (tick_o) begin
      // The divisor only changes here, so a running period is never cut short.
      cnt_d      = use_int - INT_W'(1) + INT_W'(sum[FRAC_W]);
      acc_d      = sum[FRAC_W-1:0];
      act_int_d  = use_int;
      act_frac_d = use_frac;
    end else if (en_i) begin
      cnt_d = cnt_q - INT_W'(1);
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of block evaluation order.
    if (rst) begin
      cnt_q      <= RST_CNT;
      acc_q      <= '0;
      act_int_q  <= RST_INT;
      act_frac_q <= RST_FRAC;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
    end
  end

endmodule

// File: rtl/baud_gen_frac.sv
// UART baud tick generator with a runtime fractional divisor: an rx channel
// ticking at the oversample rate and a tx channel ticking once per bit.
module baud_gen_frac
  import baud_gen_frac_pkg::*;
#(
  parameter int DIV_INT_W      = 16,
  parameter int DIV_FRAC_W     = 4,
  parameter int OSR            = OSR_DEFAULT,  // power of two, 2..64
  parameter int RESET_DIV_INT  = RESET_DIV_INT_DEFAULT,
  parameter int RESET_DIV_FRAC = RESET_DIV_FRAC_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIV_INT_W-1:0]    div_int,
  input  logic [DIV_FRAC_W-1:0]   div_frac,
  input  logic                    div_wr,
  input  logic                    rx_resync,
  output logic                    rxclk_en,
  output logic                    txclk_en,
  output logic [$clog2(OSR)-1:0]  rx_phase
);

  localparam int OSR_L2   = $clog2(OSR);
  localparam int TX_INT_W = DIV_INT_W + OSR_L2 + 1;

  // Reset divisors and starting counts for both channels.
  localparam logic [DIV_INT_W-1:0]  RST_INT  = DIV_INT_W'(eff_int(32'(RESET_DIV_INT)));
  localparam logic [DIV_FRAC_W-1:0] RST_FRAC = DIV_FRAC_W'(RESET_DIV_FRAC);
  localparam logic [TX_INT_W-1:0]   RST_TX_INT =
    TX_INT_W'(tx_scale_int(32'(RST_INT), 32'(RST_FRAC), OSR_L2, DIV_FRAC_W));
  localparam logic [DIV_FRAC_W-1:0] RST_TX_FRAC =
    DIV_FRAC_W'(tx_scale_frac(32'(RST_FRAC), OSR_L2, DIV_FRAC_W));
  localparam logic [TX_INT_W-1:0]   RST_TX_CNT =
    TX_INT_W'((64'(RST_INT) << OSR_L2) - 64'd1);

  logic [DIV_INT_W-1:0]  shd_int_q, shd_int_d;
  logic [DIV_FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic                  rx_pend_q, rx_pend_d;
  logic                  tx_pend_q, tx_pend_d;
  logic                  rxclk_en_q, rxclk_en_d;
  logic                  txclk_en_q, txclk_en_d;
  logic [OSR_L2-1:0]     rx_phase_q, rx_phase_d;

  logic [DIV_INT_W-1:0]  rx_src_int;
  logic [DIV_FRAC_W-1:0] rx_src_frac;
  logic [DIV_INT_W-1:0]  rx_int;
  logic [TX_INT_W-1:0]   tx_int;
  logic [DIV_FRAC_W-1:0] tx_frac;
  logic                  rx_tick;
  logic                  tx_tick;

  // A resync in the same cycle as a write uses the value being written.
  assign rx_src_int  = (rx_resync && div_wr) ? div_int  : shd_int_q;
  assign rx_src_frac = (rx_resync && div_wr) ? div_frac : shd_frac_q;
  assign rx_int      = DIV_INT_W'(eff_int(32'(rx_src_int)));

  // tx runs OSR times slower; the scaled fraction spills into whole clocks.
  assign tx_int  = TX_INT_W'(tx_scale_int(eff_int(32'(shd_int_q)), 32'(shd_frac_q),
                                          OSR_L2, DIV_FRAC_W));
  assign tx_frac = DIV_FRAC_W'(tx_scale_frac(32'(shd_frac_q), OSR_L2, DIV_FRAC_W));

  baud_frac_div #(
    .INT_W    (DIV_INT_W),
    .FRAC_W   (DIV_FRAC_W),
    .RST_INT  (RST_INT),
    .RST_FRAC (RST_FRAC),
    .RST_CNT  (RST_INT - DIV_INT_W'(1))
  ) u_rx_div (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .int_i     (rx_int),
    .frac_i    (rx_src_frac),
    .load_ok_i (rx_pend_q),
    .restart_i (rx_resync),
    .tick_o    (rx_tick)
  );

  baud_frac_div #(
    .INT_W    (TX_INT_W),
    .FRAC_W   (DIV_FRAC_W),
    .RST_INT  (RST_TX_INT),
    .RST_FRAC (RST_TX_FRAC),
    .RST_CNT  (RST_TX_CNT)
  ) u_tx_div (
    .clk       (clk),
    .rst       (rst),
    .en_i      (en),
    .int_i     (tx_int),
    .frac_i    (tx_frac),
    .load_ok_i (tx_pend_q),
    .restart_i (1'b0),
    .tick_o    (tx_tick)
  );

  // Shadow capture, per-channel pending flags, rx phase and output pulses.
  always_comb begin
    shd_int_d  = shd_int_q;
    shd_frac_d = shd_frac_q;
    if (div_wr) begin
      shd_int_d  = div_int;
      shd_frac_d = div_frac;
    end
    // A write landing on a tick is adopted at the following tick; a write
    // together with a resync is adopted immediately by the rx restart.
    rx_pend_d = div_wr ? !rx_resync : (rx_pend_q && !rx_tick && !rx_resync);
    tx_pend_d = div_wr || (tx_pend_q && !tx_tick);

    rxclk_en_d = rx_tick;
    txclk_en_d = tx_tick;
    rx_phase_d = rx_phase_q;
    if (rx_resync) begin
      rx_phase_d = '0;
    end else if (rx_tick) begin
      rx_phase_d = rx_phase_q + OSR_L2'(1);
    end
  end

  // Top-level state register; every flop has a reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_int_q  <= RST_INT;
      shd_frac_q <= RST_FRAC;
      rx_pend_q  <= 1'b0;
      tx_pend_q  <= 1'b0;
      rxclk_en_q <= 1'b0;
      txclk_en_q <= 1'b0;
      rx_phase_q <= '0;
    end else begin
      shd_int_q  <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      rx_pend_q  <= rx_pend_d;
      tx_pend_q  <= tx_pend_d;
      rxclk_en_q <= rxclk_en_d;
      txclk_en_q <= txclk_en_d;
      rx_phase_q <= rx_phase_d;
    end
  end

  assign rxclk_en = rxclk_en_q;
  assign txclk_en = txclk_en_q;
  assign rx_phase = rx_phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac. Pulses are logged by the clock edge that
// first captures them (edge 1 = first posedge after reset release).
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        div_wr;
  logic        rx_resync;
  logic        rxclk_en;
  logic        txclk_en;
  logic [3:0]  rx_phase;

  int cyc;
  int rx_q[$];
  int ph_q[$];
  int tx_q[$];
  int n_checks = 0;
  int n_errors = 0;

  baud_gen_frac dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .div_wr    (div_wr),
    .rx_resync (rx_resync),
    .rxclk_en  (rxclk_en),
    .txclk_en  (txclk_en),
    .rx_phase  (rx_phase)
  );

  always #5 clk = ~clk;

  // Posedges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Log each pulse with the index of the edge that captures it.
  always @(negedge clk) begin
    if (!rst) begin
      if (rxclk_en) begin
        rx_q.push_back(cyc + 1);
        ph_q.push_back(int'(rx_phase));
      end
      if (txclk_en) tx_q.push_back(cyc + 1);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int count_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] <= hi) n++;
    return n;
  endfunction

  // Wait at negedges until the next edge is edge n.
  task automatic run_to(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  // Present strobes so that edge n samples them.
  task automatic drive(input int n, input logic wr, input logic rs,
                       input logic [15:0] di, input logic [3:0] df);
    run_to(n);
    div_int   = di;
    div_frac  = df;
    div_wr    = wr;
    rx_resync = rs;
    @(negedge clk);
    div_wr    = 1'b0;
    rx_resync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    en        = 1'b1;
    div_wr    = 1'b0;
    rx_resync = 1'b0;
    div_int   = '0;
    div_frac  = '0;
    repeat (2) @(negedge clk);
    rx_q.delete();
    ph_q.delete();
    tx_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    bit found;
    rst = 1'b1; en = 1'b1; div_wr = 1'b0; rx_resync = 1'b0;
    div_int = '0; div_frac = '0;
    repeat (2) @(negedge clk);
    check("rst_rxclk_en", rxclk_en, 0);
    check("rst_txclk_en", txclk_en, 0);
    check("rst_rx_phase", rx_phase, 0);

    // Reset divisor 27 + 2/16: periods 27 except every 8th is 28; tx 434.
    do_reset();
    run_to(1000);
    check("t1_first_rx_edge",  qat(rx_q, 0), 28);
    check("t1_rx_period_1",    qat(rx_q, 1) - qat(rx_q, 0), 27);
    check("t1_rx_period_8",    qat(rx_q, 8) - qat(rx_q, 7), 28);
    check("t1_rx_16_span",     qat(rx_q, 16) - qat(rx_q, 0), 434);
    check("t1_phase_p1",       qat(ph_q, 0), 1);
    check("t1_phase_p15",      qat(ph_q, 14), 15);
    check("t1_phase_wrap_p16", qat(ph_q, 15), 0);
    check("t1_first_tx_edge",  qat(tx_q, 0), 433);
    check("t1_tx_period",      qat(tx_q, 1) - qat(tx_q, 0), 434);

    // Write 4.5 mid-period: old 27 finishes, then 4,5,4,5; tx 72.
    do_reset();
    drive(38, 1'b1, 1'b0, 16'd4, 4'd8);
    run_to(620);
    check("t2_old_period", qat(rx_q, 1), 55);
    check("t2_rx_p3",      qat(rx_q, 2), 59);
    check("t2_rx_p4",      qat(rx_q, 3), 64);
    check("t2_rx_p5",      qat(rx_q, 4), 68);
    check("t2_rx_p6",      qat(rx_q, 5), 73);
    check("t2_phase_p6",   qat(ph_q, 5), 6);
    check("t2_tx_first",   qat(tx_q, 0), 433);
    check("t2_tx_p2",      qat(tx_q, 1), 505);
    check("t2_tx_p3",      qat(tx_q, 2), 577);

    // Back-to-back writes, last one 0.0: rx every cycle, tx every 16.
    do_reset();
    drive(4, 1'b1, 1'b0, 16'd7, 4'd3);
    drive(5, 1'b1, 1'b0, 16'd0, 4'd0);
    run_to(480);
    check("t3_rx_p1",       qat(rx_q, 0), 28);
    check("t3_rx_p2",       qat(rx_q, 1), 29);
    check("t3_rx_p6",       qat(rx_q, 5), 33);
    check("t3_phase_wrap",  qat(ph_q, 15), 0);
    check("t3_tx_p2",       qat(tx_q, 1), 449);
    check("t3_tx_p3",       qat(tx_q, 2), 465);

    // Resync 5 cycles after a tick, then a resync landing on a due tick.
    do_reset();
    drive(59, 1'b0, 1'b1, 16'd0, 4'd0);
    check("t4_phase_after_resync", rx_phase, 0);
    drive(113, 1'b0, 1'b1, 16'd0, 4'd0);
    check("t4_suppressed_pulse", rxclk_en, 0);
    run_to(900);
    check("t4_phase_before", qat(ph_q, 1), 2);
    check("t4_rx_after_rs1", qat(rx_q, 2), 87);
    check("t4_phase_rs1",    qat(ph_q, 2), 1);
    check("t4_rx_after_rs2", qat(rx_q, 3), 141);
    check("t4_phase_rs2",    qat(ph_q, 3), 1);
    check("t4_tx_p1",        qat(tx_q, 0), 433);
    check("t4_tx_p2",        qat(tx_q, 1), 867);

    // Resync together with a write of 10.0 uses the new divisor at once.
    do_reset();
    drive(40, 1'b1, 1'b1, 16'd10, 4'd0);
    run_to(620);
    check("t5_rx_p2",    qat(rx_q, 1), 51);
    check("t5_rx_p3",    qat(rx_q, 2), 61);
    check("t5_rx_p4",    qat(rx_q, 3), 71);
    check("t5_phase_p2", qat(ph_q, 1), 1);
    check("t5_tx_p2",    qat(tx_q, 1), 593);

    // en low for edges 40..139 freezes the period in progress.
    do_reset();
    run_to(40);
    en = 1'b0;
    run_to(140);
    en = 1'b1;
    run_to(560);
    check("t6_no_rx_while_off", count_in(rx_q, 41, 154), 0);
    check("t6_rx_resume",       qat(rx_q, 1) - qat(rx_q, 0), 127);
    check("t6_phase_held",      qat(ph_q, 1), 2);
    check("t6_tx_delayed",      qat(tx_q, 0), 533);

    // Asynchronous reset during a pulse after a 4.5 write.
    do_reset();
    drive(10, 1'b1, 1'b0, 16'd4, 4'd8);
    run_to(40);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (rxclk_en) found = 1'b1;
    end
    check("t7_pulse_before_rst", found, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_async_rxclk_en", rxclk_en, 0);
    check("t7_async_rx_phase", rx_phase, 0);
    check("t7_async_txclk_en", txclk_en, 0);
    @(negedge clk);
    rx_q.delete();
    ph_q.delete();
    tx_q.delete();
    rst = 1'b0;
    run_to(100);
    check("t7_first_rx_edge", qat(rx_q, 0), 28);
    check("t7_reverted_period", qat(rx_q, 1) - qat(rx_q, 0), 27);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
